health_ctrl: RTL and testbench
==============================

Name: health_ctrl

Overview:
- Per-frame game-health controller for the VGA dodge game.
- On each frame tick it checks the enemy occupancy row at the player's lane and applies damage.
- After a hit it enforces an invulnerability window, tracks remaining health and sequences the IDLE / PLAY / OVER game states.
- Sits between the player/enemy position logic and the VGA overlay and score logic.

Parameters:
LANES, 8, number of horizontal lanes; width of enemy_row.
MAX_HEALTH, 3, health loaded on game start (1..15).
IFRAMES, 60, frame ticks of invulnerability after a hit (1..255).
REGEN_FRAMES, 600, hit-free frame ticks per +1 health; used only with HEALTH_REGEN_EN (1..65535).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts a game
frame_tick  in  1  one-cycle pulse, once per VGA frame
user_lane  in  8  player lane index
enemy_row  in  LANES  bit i set = enemy occupies lane i on the player's row
health  out  4  remaining health
hit  out  1  one-cycle damage pulse
invuln  out  1  high while the invulnerability window is active
playing  out  1  high in PLAY
game_over  out  1  high in OVER

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; health=0; hit=0; invuln=0; playing=0; game_over=0.
  - iframe_cnt=0; regen_cnt=0.
- State encoding: IDLE=0, PLAY=1, OVER=2. All outputs are registered.
- IDLE:
  - start → PLAY; health=MAX_HEALTH; iframe_cnt=0; regen_cnt=0.
  - frame_tick is ignored.
- PLAY, on a frame_tick cycle:
  - collide = (user_lane < LANES) && enemy_row[user_lane]. A user_lane of LANES or more never collides.
  - If iframe_cnt != 0: iframe_cnt decrements and no damage is applied, even if collide.
  - If collide and iframe_cnt == 0:
    - health decrements by 1.
    - hit=1 for exactly the next cycle.
    - iframe_cnt=IFRAMES.
    - If health was 1, state → OVER on the same edge. health reads 0 and hit still pulses.
- invuln = (iframe_cnt != 0), registered alongside iframe_cnt.
- Latency: enemy_row and user_lane are sampled on the frame_tick edge. hit, health and state update on that same edge and are visible the following cycle.
- start in PLAY is ignored. start in OVER → PLAY with a full reload, same as IDLE.
- start and frame_tick in the same cycle (IDLE/OVER): start wins and the tick is discarded. No collision is evaluated that cycle.
- Inputs outside a frame_tick cycle have no effect.
- health never underflows below 0 and never exceeds MAX_HEALTH.
- OVER: game_over=1; health holds 0; iframe_cnt clears to 0.
- Reset mid-game: immediate return to IDLE, all counters cleared, no hit pulse.

Optional Feature:
- Macro: HEALTH_REGEN_EN.
- Defined:
  - In PLAY, regen_cnt increments on each frame_tick that applies no damage.
  - A damaging hit clears regen_cnt.
  - When regen_cnt reaches REGEN_FRAMES-1 on a tick:
    - If health < MAX_HEALTH, health increments and regen_cnt=0.
    - At MAX_HEALTH, health holds and regen_cnt=0.
  - A regen tick never coincides with a damage tick; damage takes priority.
- Undefined: no regen_cnt register; health only decreases during PLAY.

Test Plan:
- Reset, then start pulse → playing=1, health=3, invuln=0, hit=0 one cycle later.
- PLAY, user_lane=2, enemy_row=8'b0000_0100, frame_tick → hit=1 for one cycle, health=2, invuln=1. The same collision on the next 60 ticks → no hit, health stays 2, and invuln drops after the 60th tick.
- Three damaging hits spaced more than IFRAMES apart → health 3→2→1→0. game_over=1 and playing=0 the cycle after the third hit. A subsequent start → health=3, playing=1.
- user_lane=9 with enemy_row=8'hFF, frame_tick → no hit, health unchanged. start and frame_tick in the same cycle in IDLE → PLAY, health=3, no hit.
- Assert rst low mid-PLAY with iframe_cnt=30 → all outputs 0 asynchronously, without waiting for a clock edge. After release, state stays IDLE until start.
- HEALTH_REGEN_EN with REGEN_FRAMES=4, health=2 → after 4 hit-free ticks health=3. Another 4 ticks → health holds at 3.

Source files
------------

// File: rtl/health_ctrl_if.sv
// Port bundle for health_ctrl: game control inputs and registered health/state outputs.
interface health_ctrl_if #(
    parameter int LANES = 8
);
    logic             start;
    logic             frame_tick;
    logic [7:0]       user_lane;
    logic [LANES-1:0] enemy_row;
    logic [3:0]       health;
    logic             hit;
    logic             invuln;
    logic             playing;
    logic             game_over;

    modport master (
        output start, frame_tick, user_lane, enemy_row,
        input  health, hit, invuln, playing, game_over
    );

    modport slave (
        input  start, frame_tick, user_lane, enemy_row,
        output health, hit, invuln, playing, game_over
    );
endinterface

// File: rtl/health_ctrl.sv
// Per-frame health controller for the dodge game: damage, invulnerability window, IDLE/PLAY/OVER.
// Optional health regeneration is built when HEALTH_REGEN_EN is defined.
module health_ctrl #(
    parameter int LANES        = 8,
    parameter int MAX_HEALTH   = 3,
    parameter int IFRAMES      = 60,
    parameter int REGEN_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst,
    health_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [3:0] MAX_H   = 4'(MAX_HEALTH);
    localparam logic [7:0] IFR_LEN = 8'(IFRAMES);

    state_t     state_q, state_d;
    logic [3:0] health_q, health_d;
    logic [7:0] iframe_q, iframe_d;
    logic       hit_q, hit_d;
    logic       invuln_q, playing_q, game_over_q;
    logic       collide;
    logic       damage;

`ifdef HEALTH_REGEN_EN
    localparam logic [15:0] REGEN_LAST = 16'(REGEN_FRAMES - 1);
    logic [15:0] regen_q, regen_d;
`endif

    // Loop compare keeps out-of-range lanes from ever indexing enemy_row.
    always_comb begin
        collide = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (32'(bus.user_lane) == i && bus.enemy_row[i]) collide = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        iframe_d = iframe_q;
        hit_d    = 1'b0;
        damage   = 1'b0;
`ifdef HEALTH_REGEN_EN
        regen_d  = regen_q;
`endif
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d  = PLAY;
                    health_d = MAX_H;
                    iframe_d = '0;
`ifdef HEALTH_REGEN_EN
                    regen_d  = '0;
`endif
                end else if (state_q == OVER) begin
                    health_d = '0;
                    iframe_d = '0;
                end
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    if (iframe_q != '0) begin
                        iframe_d = iframe_q - 8'd1;
                    end else if (collide) begin
                        damage   = 1'b1;
                        hit_d    = 1'b1;
                        iframe_d = IFR_LEN;
                        if (health_q != '0) health_d = health_q - 4'd1;
                        if (health_q <= 4'd1) begin
                            state_d  = OVER;
                            iframe_d = '0;
                        end
                    end
`ifdef HEALTH_REGEN_EN
                    if (damage) begin
                        regen_d = '0;
                    end else if (regen_q >= REGEN_LAST) begin
                        regen_d = '0;
                        if (health_q < MAX_H) health_d = health_q + 4'd1;
                    end else begin
                        regen_d = regen_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            health_q    <= '0;
            iframe_q    <= '0;
            hit_q       <= 1'b0;
            invuln_q    <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            health_q    <= health_d;
            iframe_q    <= iframe_d;
            hit_q       <= hit_d;
            invuln_q    <= (iframe_d != '0);
            playing_q   <= (state_d == PLAY);
            game_over_q <= (state_d == OVER);
        end
    end

`ifdef HEALTH_REGEN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regen_q <= '0;
        else      regen_q <= regen_d;
    end
`endif

    assign bus.health    = health_q;
    assign bus.hit       = hit_q;
    assign bus.invuln    = invuln_q;
    assign bus.playing   = playing_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_health_ctrl.sv
// Directed self-checking bench for health_ctrl (default parameters, REGEN_FRAMES=4 for the regen build).
module tb_health_ctrl;
    localparam int LANES = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    health_ctrl_if #(.LANES(LANES)) bus ();

    health_ctrl #(
        .LANES       (LANES),
        .MAX_HEALTH  (3),
        .IFRAMES     (60),
        .REGEN_FRAMES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic frame(input logic [7:0] lane, input logic [7:0] row);
        bus.user_lane  = lane;
        bus.enemy_row  = row;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic reset_dut();
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic check_outs(input string tag, input logic [3:0] h, input logic ht,
                              input logic inv, input logic pl, input logic go);
        check_eq({tag, ".health"},    32'(bus.health),    32'(h));
        check_eq({tag, ".hit"},       32'(bus.hit),       32'(ht));
        check_eq({tag, ".invuln"},    32'(bus.invuln),    32'(inv));
        check_eq({tag, ".playing"},   32'(bus.playing),   32'(pl));
        check_eq({tag, ".game_over"}, 32'(bus.game_over), 32'(go));
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        bus.user_lane  = 8'd0;
        bus.enemy_row  = 8'h00;

        #2 rst = 1'b0;
        #1 check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();

        frame(8'd2, 8'b0000_0100);
        check_outs("idle_tick_ignored", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        pulse_start();
        check_outs("start", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        frame(8'd2, 8'b0000_0100);
        check_outs("hit1", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("hit1_one_cycle", 32'(bus.hit), 32'd0);

`ifndef HEALTH_REGEN_EN
        for (int k = 1; k <= 60; k++) begin
            frame(8'd2, 8'b0000_0100);
            check_eq($sformatf("iframe_hit_%0d", k), 32'(bus.hit), 32'd0);
            check_eq($sformatf("iframe_inv_%0d", k), 32'(bus.invuln), (k < 60) ? 32'd1 : 32'd0);
        end
        check_eq("iframe_health", 32'(bus.health), 32'd2);

        frame(8'd2, 8'b0000_0100);
        check_outs("hit2", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 60; k++) frame(8'd2, 8'h00);
        check_eq("hit2_window_done", 32'(bus.invuln), 32'd0);

        frame(8'd2, 8'b0000_0100);
        check_eq("hit3.health",    32'(bus.health),    32'd0);
        check_eq("hit3.hit",       32'(bus.hit),       32'd1);
        check_eq("hit3.playing",   32'(bus.playing),   32'd0);
        check_eq("hit3.game_over", 32'(bus.game_over), 32'd1);
        frame(8'd2, 8'b0000_0100);
        check_outs("over_tick", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        pulse_start();
        check_outs("restart_from_over", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        reset_dut();
        pulse_start();
        frame(8'd9, 8'hFF);
        check_outs("lane9", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(8'd8, 8'hFF);
        check_outs("lane8", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(8'd7, 8'h80);
        check_outs("lane7_hit", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);

        pulse_start();
        check_outs("start_in_play", 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 30; k++) frame(8'd7, 8'h00);
        check_eq("mid_play_invuln", 32'(bus.invuln), 32'd1);
        #2 rst = 1'b0;
        #1 check_outs("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        frame(8'd7, 8'h80);
        check_outs("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        bus.start      = 1'b1;
        bus.frame_tick = 1'b1;
        bus.user_lane  = 8'd2;
        bus.enemy_row  = 8'b0000_0100;
        step();
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        check_outs("start_and_tick", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        step();
        check_outs("no_tick_no_effect", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef HEALTH_REGEN_EN
        frame(8'd2, 8'b0000_0100);
        check_eq("regen_hit", 32'(bus.health), 32'd2);
        for (int k = 1; k <= 3; k++) begin
            frame(8'd2, 8'h00);
            check_eq($sformatf("regen_wait_%0d", k), 32'(bus.health), 32'd2);
        end
        frame(8'd2, 8'h00);
        check_eq("regen_plus1", 32'(bus.health), 32'd3);
        for (int k = 1; k <= 4; k++) begin
            frame(8'd2, 8'h00);
            check_eq($sformatf("regen_hold_%0d", k), 32'(bus.health), 32'd3);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
